ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage pipeline: consumes the decoded operation and operands registered by the ID/EX pipeline register and produces the write-back bundle for the EX/MEM register. Single-cycle logic, shift and arithmetic operations are combinational. Signed and unsigned division run on an iterative radix-2 divider FSM that holds the pipeline with `stall_req` until the quotient and remainder are ready.

## Interface
- No parameters; data width 32, register address width 5, `alu_op` width 8, `alu_sel` width 3.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ex_alu_op` in 8: operation code from ID/EX.
- `ex_alu_sel` in 3: result class: 000 nop, 001 logic, 010 shift, 100 arith, 101 div.
- `ex_src1`, `ex_src2` in 32: operands; for shifts, src1[4:0] is the amount and src2 is the value.
- `ex_des_addr` in 5, `ex_des_exist` in 1: destination register and write request.
- `flush` in 1: cancels any in-flight division.
- `em_des_addr` out 5, `em_des_exist` out 1, `em_wdata` out 32: GPR write-back bundle.
- `em_hi`, `em_lo` out 32, `em_whilo` out 1: HI/LO write-back; HI = remainder, LO = quotient.
- `stall_req` out 1: request to hold PC, IF/ID and ID/EX.

## Operation
- Op codes: and 0x24, or 0x25, xor 0x26, nor 0x27, sll 0x7C, srl 0x02, sra 0x03, add 0x20, addu 0x21, sub 0x22, subu 0x23, slt 0x2A, sltu 0x2B, div 0x1A, divu 0x1B, nop 0x00.
- Outputs are combinational from the inputs and the divider state; the EX/MEM register provides the pipeline boundary.
- `em_des_addr` = `ex_des_addr` always. `em_wdata` is selected by `ex_alu_sel`; 000, 101 and unknown values give 0.
- Arithmetic is modulo 2^32. add/sub with signed overflow force `em_des_exist` = 0. addu/subu never trap. slt is a signed compare and sltu an unsigned compare, with result 0 or 1.
- sra replicates src2[31]; shift amount 0 passes src2 unchanged.
- Divider FSM states:
  - IDLE: on sel=101 and no flush, go to ZERO if src2 == 0, else BUSY. Latch absolute values for div, or raw values for divu, plus the result signs. Counter = 0.
  - BUSY: one restoring shift-subtract step per cycle. After 32 steps go to DONE.
  - ZERO: go to DONE next cycle; quotient = 0, remainder = 0.
  - DONE: present the sign-corrected result and go to IDLE unconditionally.
- div signs: quotient negative iff operand signs differ; remainder takes the dividend's sign. 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
- `stall_req` = 1 when sel=101 in IDLE, and in BUSY or ZERO. It is 0 in DONE and for all other ops.
- `em_whilo` = 1 only in DONE; `em_hi`/`em_lo` = 0 otherwise. Division never writes the GPR: `em_des_exist` = 0 when sel=101.
- `flush` from any state: next state is IDLE, `stall_req` drops combinationally in the same cycle, and the result is discarded with no `em_whilo` pulse.
- Upstream holds `ex_*` stable while `stall_req` = 1.

## Timing
- Reset (async): FSM to IDLE, counter 0, internal dividend/divisor/partial remainder 0. During reset `stall_req` = 0, `em_whilo` = 0, `em_hi`/`em_lo` = 0. Bundle outputs follow the inputs; for a reset ID/EX these are address 0, exist 0, data 0.
- Non-divide ops: zero latency, no stall.
- Division, with cycle 0 = first cycle the op is presented in IDLE:
  - cycles 0..32 stall, i.e. 33 stall cycles;
  - cycle 33 is DONE, with the result and `em_whilo` = 1;
  - ID/EX advances at the end of cycle 33.
- Divide by zero: cycles 0–1 stall; cycle 2 is DONE.
- Back-to-back divides: the second one enters IDLE one cycle after DONE and starts immediately.
- Reset or flush mid-BUSY aborts with no HI/LO write. A divide presented in the same cycle as flush is not started.

## Test plan
- Logic/arith sweep: add 0x7FFFFFFF+1 -> `em_des_exist` = 0. addu of the same operands -> wdata 0x80000000, exist 1. slt(-1,1) -> 1; sltu(-1,1) -> 0.
- Shifts: sra amount 4 of 0x80000010 -> 0xF8000001. srl -> 0x08000001. sll amount 0 -> unchanged.
- divu 100/7 -> `stall_req` high exactly 33 cycles, then one cycle of `em_whilo` = 1 with lo 14, hi 2. div -7/2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF.
- Divide by zero 5/0 -> 2 stall cycles, then `em_whilo` = 1 with hi = lo = 0. Overflow case 0x80000000 / -1 -> lo 0x80000000, hi 0.
- Flush at BUSY cycle 10 -> `stall_req` 0 that cycle, no `em_whilo` pulse. A following divu 9/3 completes normally: lo 3, hi 0.
- Async reset asserted mid-BUSY between clock edges -> `stall_req` and `em_whilo` go to 0 immediately. After release, a new divide takes the full 33-cycle stall.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: combinational logic/shift/arithmetic unit plus an iterative
// radix-2 restoring divider that stalls the pipeline until HI/LO are ready.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ex_alu_op,
  input  logic [2:0]  ex_alu_sel,
  input  logic [31:0] ex_src1,
  input  logic [31:0] ex_src2,
  input  logic [4:0]  ex_des_addr,
  input  logic        ex_des_exist,
  input  logic        flush,
  output logic [4:0]  em_des_addr,
  output logic        em_des_exist,
  output logic [31:0] em_wdata,
  output logic [31:0] em_hi,
  output logic [31:0] em_lo,
  output logic        em_whilo,
  output logic        stall_req
);

  localparam logic [7:0] OP_AND  = 8'h24, OP_OR   = 8'h25, OP_XOR  = 8'h26, OP_NOR = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C, OP_SRL  = 8'h02, OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h20, OP_ADDU = 8'h21, OP_SUB  = 8'h22, OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A, OP_SLTU = 8'h2B, OP_DIV  = 8'h1A;

  localparam logic [2:0] SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010, SEL_ARITH = 3'b100, SEL_DIV = 3'b101;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_ZERO = 2'd2, S_DONE = 2'd3} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_divisor;
  logic        r_q_neg;
  logic        r_r_neg;

  logic [31:0] w_logic;
  logic [31:0] w_shift;
  logic [31:0] w_arith;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic        w_ovf_add;
  logic        w_ovf_sub;
  logic        w_is_div;
  logic        w_signed;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [32:0] w_trial;
  logic [32:0] w_sub_res;

  assign w_sum     = ex_src1 + ex_src2;
  assign w_diff    = ex_src1 - ex_src2;
  assign w_ovf_add = (ex_src1[31] == ex_src2[31]) && (w_sum[31] != ex_src1[31]);
  assign w_ovf_sub = (ex_src1[31] != ex_src2[31]) && (w_diff[31] != ex_src1[31]);
  assign w_is_div  = (ex_alu_sel == SEL_DIV);
  assign w_signed  = (ex_alu_op == OP_DIV);
  assign w_abs1    = (w_signed && ex_src1[31]) ? (32'd0 - ex_src1) : ex_src1;
  assign w_abs2    = (w_signed && ex_src2[31]) ? (32'd0 - ex_src2) : ex_src2;
  // Restoring step: shift the next dividend bit into the partial remainder and try to subtract.
  assign w_trial   = {r_rem, r_quo[31]};
  assign w_sub_res = w_trial - {1'b0, r_divisor};

  always_comb begin
    w_logic = 32'd0;
    w_shift = 32'd0;
    w_arith = 32'd0;
    case (ex_alu_op)
      OP_AND:  w_logic = ex_src1 & ex_src2;
      OP_OR:   w_logic = ex_src1 | ex_src2;
      OP_XOR:  w_logic = ex_src1 ^ ex_src2;
      OP_NOR:  w_logic = ~(ex_src1 | ex_src2);
      default: w_logic = 32'd0;
    endcase
    case (ex_alu_op)
      OP_SLL:  w_shift = ex_src2 << ex_src1[4:0];
      OP_SRL:  w_shift = ex_src2 >> ex_src1[4:0];
      OP_SRA:  w_shift = $unsigned($signed(ex_src2) >>> ex_src1[4:0]);
      default: w_shift = 32'd0;
    endcase
    case (ex_alu_op)
      OP_ADD, OP_ADDU: w_arith = w_sum;
      OP_SUB, OP_SUBU: w_arith = w_diff;
      OP_SLT:  w_arith = {31'd0, ($signed(ex_src1) < $signed(ex_src2))};
      OP_SLTU: w_arith = {31'd0, (ex_src1 < ex_src2)};
      default: w_arith = 32'd0;
    endcase
  end

  always_comb begin
    em_des_addr  = ex_des_addr;
    em_des_exist = ex_des_exist;
    em_wdata     = 32'd0;
    case (ex_alu_sel)
      SEL_LOGIC: em_wdata = w_logic;
      SEL_SHIFT: em_wdata = w_shift;
      SEL_ARITH: begin
        em_wdata = w_arith;
        if ((ex_alu_op == OP_ADD && w_ovf_add) || (ex_alu_op == OP_SUB && w_ovf_sub)) begin
          em_des_exist = 1'b0;
        end else begin
          em_des_exist = ex_des_exist;
        end
      end
      SEL_DIV:   em_des_exist = 1'b0;
      default:   em_wdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_div) begin
            w_next = (ex_src2 == 32'd0) ? S_ZERO : S_BUSY;
          end else begin
            w_next = S_IDLE;
          end
        end
        S_BUSY: begin
          if (r_cnt == 5'd31) begin
            w_next = S_DONE;
          end else begin
            w_next = S_BUSY;
          end
        end
        S_ZERO:  w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_req = 1'b0;
    em_whilo  = 1'b0;
    em_hi     = 32'd0;
    em_lo     = 32'd0;
    if (rst || flush) begin
      stall_req = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: stall_req = w_is_div;
        S_BUSY, S_ZERO: stall_req = 1'b1;
        S_DONE: begin
          em_whilo = 1'b1;
          em_lo    = r_q_neg ? (32'd0 - r_quo) : r_quo;
          em_hi    = r_r_neg ? (32'd0 - r_rem) : r_rem;
        end
        default: stall_req = 1'b0;
      endcase
    end
  end

  // Divider datapath: r_quo starts as the dividend and fills with quotient bits as it shifts out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 5'd0;
      r_quo     <= 32'd0;
      r_rem     <= 32'd0;
      r_divisor <= 32'd0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_div && !flush) begin
            r_cnt     <= 5'd0;
            r_quo     <= w_abs1;
            r_rem     <= 32'd0;
            r_divisor <= w_abs2;
            r_q_neg   <= w_signed && (ex_src1[31] ^ ex_src2[31]);
            r_r_neg   <= w_signed && ex_src1[31];
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 5'd1;
          if (!w_sub_res[32]) begin
            r_rem <= w_sub_res[31:0];
            r_quo <= {r_quo[30:0], 1'b1};
          end else begin
            r_rem <= w_trial[31:0];
            r_quo <= {r_quo[30:0], 1'b0};
          end
        end
        S_ZERO: begin
          r_quo <= 32'd0;
          r_rem <= 32'd0;
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU classes, divider latency,
// signed/zero/overflow division, flush, async reset and back-to-back divides.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ex_alu_op;
  logic [2:0]  ex_alu_sel;
  logic [31:0] ex_src1;
  logic [31:0] ex_src2;
  logic [4:0]  ex_des_addr;
  logic        ex_des_exist;
  logic        flush;
  logic [4:0]  em_des_addr;
  logic        em_des_exist;
  logic [31:0] em_wdata;
  logic [31:0] em_hi;
  logic [31:0] em_lo;
  logic        em_whilo;
  logic        stall_req;

  int n_cmp = 0;
  int n_err = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .ex_alu_op(ex_alu_op), .ex_alu_sel(ex_alu_sel),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_des_addr(ex_des_addr),
    .ex_des_exist(ex_des_exist), .flush(flush), .em_des_addr(em_des_addr),
    .em_des_exist(em_des_exist), .em_wdata(em_wdata), .em_hi(em_hi), .em_lo(em_lo),
    .em_whilo(em_whilo), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    ex_alu_sel   = sel;
    ex_alu_op    = op;
    ex_src1      = a;
    ex_src2      = b;
    ex_des_addr  = 5'd9;
    ex_des_exist = 1'b1;
  endtask

  // Present a divide after the next rising edge and run it to the first non-stall cycle.
  task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output int early, output logic whilo,
                        output logic [31:0] hi, output logic [31:0] lo, output logic exist);
    @(posedge clk); #1;
    drive(3'b101, op, a, b);
    stalls = 0;
    early  = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (stall_req !== 1'b1) break;
      stalls++;
      if (em_whilo !== 1'b0) early++;
    end
    whilo = em_whilo;
    hi    = em_hi;
    lo    = em_lo;
    exist = em_des_exist;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(3'b000, 8'h00, 32'd0, 32'd0);
    ex_des_addr  = 5'd0;
    ex_des_exist = 1'b0;
    flush = 1'b0;
    #12;
    n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall got %0b exp 0", stall_req); end
    n_cmp++; if (em_whilo !== 1'b0) begin n_err++; $display("FAIL reset_whilo got %0b exp 0", em_whilo); end
    n_cmp++; if ({em_hi, em_lo} !== 64'd0) begin n_err++; $display("FAIL reset_hilo got %h exp 0", {em_hi, em_lo}); end
    n_cmp++; if ({em_des_addr, em_des_exist, em_wdata} !== 38'd0) begin n_err++; $display("FAIL reset_bundle got %h exp 0", {em_des_addr, em_des_exist, em_wdata}); end
    // A divide request held during reset must not stall.
    drive(3'b101, 8'h1B, 32'd10, 32'd2);
    #1;
    n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL reset_div_stall got %0b exp 0", stall_req); end
    drive(3'b000, 8'h00, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_logic;
    @(posedge clk); #1;
    drive(3'b001, 8'h24, 32'hF0F0_1234, 32'h0FF0_00FF); #1;
    n_cmp++; if (em_wdata !== 32'h00F0_0034) begin n_err++; $display("FAIL and got %h exp 00f00034", em_wdata); end
    n_cmp++; if (em_des_addr !== 5'd9 || em_des_exist !== 1'b1) begin n_err++; $display("FAIL and_bundle got %0d/%0b exp 9/1", em_des_addr, em_des_exist); end
    ex_alu_op = 8'h25; #1;
    n_cmp++; if (em_wdata !== 32'hFFF0_12FF) begin n_err++; $display("FAIL or got %h exp fff012ff", em_wdata); end
    ex_alu_op = 8'h26; #1;
    n_cmp++; if (em_wdata !== 32'hFF00_12CB) begin n_err++; $display("FAIL xor got %h exp ff0012cb", em_wdata); end
    ex_alu_op = 8'h27; #1;
    n_cmp++; if (em_wdata !== 32'h000F_ED00) begin n_err++; $display("FAIL nor got %h exp 000fed00", em_wdata); end
    ex_alu_sel = 3'b000; #1;
    n_cmp++; if (em_wdata !== 32'd0) begin n_err++; $display("FAIL nop_sel got %h exp 0", em_wdata); end
    ex_alu_sel = 3'b111; #1;
    n_cmp++; if (em_wdata !== 32'd0) begin n_err++; $display("FAIL unknown_sel got %h exp 0", em_wdata); end
  endtask

  task automatic test_arith;
    drive(3'b100, 8'h20, 32'h7FFF_FFFF, 32'd1); #1;
    n_cmp++; if (em_des_exist !== 1'b0) begin n_err++; $display("FAIL add_ovf_exist got %0b exp 0", em_des_exist); end
    ex_alu_op = 8'h21; #1;
    n_cmp++; if (em_wdata !== 32'h8000_0000 || em_des_exist !== 1'b1) begin n_err++; $display("FAIL addu got %h/%0b exp 80000000/1", em_wdata, em_des_exist); end
    drive(3'b100, 8'h22, 32'd5, 32'd7); #1;
    n_cmp++; if (em_wdata !== 32'hFFFF_FFFE || em_des_exist !== 1'b1) begin n_err++; $display("FAIL sub got %h/%0b exp fffffffe/1", em_wdata, em_des_exist); end
    drive(3'b100, 8'h22, 32'h8000_0000, 32'd1); #1;
    n_cmp++; if (em_des_exist !== 1'b0) begin n_err++; $display("FAIL sub_ovf_exist got %0b exp 0", em_des_exist); end
    ex_alu_op = 8'h23; #1;
    n_cmp++; if (em_wdata !== 32'h7FFF_FFFF || em_des_exist !== 1'b1) begin n_err++; $display("FAIL subu got %h/%0b exp 7fffffff/1", em_wdata, em_des_exist); end
    drive(3'b100, 8'h2A, 32'hFFFF_FFFF, 32'd1); #1;
    n_cmp++; if (em_wdata !== 32'd1) begin n_err++; $display("FAIL slt got %h exp 1", em_wdata); end
    ex_alu_op = 8'h2B; #1;
    n_cmp++; if (em_wdata !== 32'd0) begin n_err++; $display("FAIL sltu got %h exp 0", em_wdata); end
    n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL arith_stall got %0b exp 0", stall_req); end
  endtask

  task automatic test_shift;
    drive(3'b010, 8'h03, 32'd4, 32'h8000_0010); #1;
    n_cmp++; if (em_wdata !== 32'hF800_0001) begin n_err++; $display("FAIL sra got %h exp f8000001", em_wdata); end
    ex_alu_op = 8'h02; #1;
    n_cmp++; if (em_wdata !== 32'h0800_0001) begin n_err++; $display("FAIL srl got %h exp 08000001", em_wdata); end
    drive(3'b010, 8'h7C, 32'd0, 32'h1234_5678); #1;
    n_cmp++; if (em_wdata !== 32'h1234_5678) begin n_err++; $display("FAIL sll0 got %h exp 12345678", em_wdata); end
    ex_src1 = 32'hFFFF_FFE4; #1;
    n_cmp++; if (em_wdata !== 32'h2345_6780) begin n_err++; $display("FAIL sll4 got %h exp 23456780", em_wdata); end
  endtask

  task automatic test_divu;
    int s, e; logic w, x; logic [31:0] h, l;
    do_div(8'h1B, 32'd100, 32'd7, s, e, w, h, l, x);
    n_cmp++; if (s !== 33) begin n_err++; $display("FAIL divu_stalls got %0d exp 33", s); end
    n_cmp++; if (e !== 0) begin n_err++; $display("FAIL divu_early_whilo got %0d exp 0", e); end
    n_cmp++; if (w !== 1'b1 || l !== 32'd14 || h !== 32'd2) begin n_err++; $display("FAIL divu_result got w%0b lo %h hi %h exp w1 lo e hi 2", w, l, h); end
    n_cmp++; if (x !== 1'b0) begin n_err++; $display("FAIL divu_exist got %0b exp 0", x); end
    @(posedge clk); #1;
    drive(3'b000, 8'h00, 32'd0, 32'd0);
    @(negedge clk);
    n_cmp++; if (em_whilo !== 1'b0 || em_lo !== 32'd0) begin n_err++; $display("FAIL divu_pulse_end got %0b/%h exp 0/0", em_whilo, em_lo); end
  endtask

  task automatic test_div_signed;
    int s, e; logic w, x; logic [31:0] h, l;
    do_div(8'h1A, 32'hFFFF_FFF9, 32'd2, s, e, w, h, l, x);
    n_cmp++; if (s !== 33 || w !== 1'b1 || l !== 32'hFFFF_FFFD || h !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_neg got s%0d w%0b lo %h hi %h exp 33/1/fffffffd/ffffffff", s, w, l, h); end
    do_div(8'h1A, 32'h8000_0000, 32'hFFFF_FFFF, s, e, w, h, l, x);
    n_cmp++; if (s !== 33 || w !== 1'b1 || l !== 32'h8000_0000 || h !== 32'd0) begin n_err++; $display("FAIL div_ovf got s%0d w%0b lo %h hi %h exp 33/1/80000000/0", s, w, l, h); end
    do_div(8'h1B, 32'd5, 32'd0, s, e, w, h, l, x);
    n_cmp++; if (s !== 2 || w !== 1'b1 || l !== 32'd0 || h !== 32'd0) begin n_err++; $display("FAIL div_zero got s%0d w%0b lo %h hi %h exp 2/1/0/0", s, w, l, h); end
    @(posedge clk); #1;
    drive(3'b000, 8'h00, 32'd0, 32'd0);
  endtask

  task automatic test_flush;
    int s, e, seen; logic w, x; logic [31:0] h, l;
    @(posedge clk); #1;
    drive(3'b101, 8'h1B, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    #1;
    n_cmp++; if (stall_req !== 1'b0 || em_whilo !== 1'b0) begin n_err++; $display("FAIL flush_now got stall %0b whilo %0b exp 0/0", stall_req, em_whilo); end
    @(posedge clk); #1;
    flush = 1'b0;
    drive(3'b000, 8'h00, 32'd0, 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (em_whilo !== 1'b0 || stall_req !== 1'b0) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL flush_no_pulse got %0d active cycles exp 0", seen); end
    do_div(8'h1B, 32'd9, 32'd3, s, e, w, h, l, x);
    n_cmp++; if (s !== 33 || w !== 1'b1 || l !== 32'd3 || h !== 32'd0) begin n_err++; $display("FAIL flush_next got s%0d w%0b lo %h hi %h exp 33/1/3/0", s, w, l, h); end
    // A divide presented together with flush must not start.
    @(posedge clk); #1;
    drive(3'b101, 8'h1B, 32'd9, 32'd3);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    drive(3'b000, 8'h00, 32'd0, 32'd0);
    #1;
    n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL flush_same_cycle got stall %0b exp 0", stall_req); end
  endtask

  task automatic test_reset_mid_busy;
    int s, e; logic w, x; logic [31:0] h, l;
    @(posedge clk); #1;
    drive(3'b101, 8'h1B, 32'd50, 32'd5);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (stall_req !== 1'b0 || em_whilo !== 1'b0 || em_lo !== 32'd0) begin n_err++; $display("FAIL rst_mid got stall %0b whilo %0b lo %h exp 0/0/0", stall_req, em_whilo, em_lo); end
    drive(3'b000, 8'h00, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_div(8'h1B, 32'd50, 32'd5, s, e, w, h, l, x);
    n_cmp++; if (s !== 33 || w !== 1'b1 || l !== 32'd10 || h !== 32'd0) begin n_err++; $display("FAIL rst_after got s%0d w%0b lo %h hi %h exp 33/1/a/0", s, w, l, h); end
  endtask

  task automatic test_back_to_back;
    int s, e; logic w, x; logic [31:0] h, l;
    do_div(8'h1B, 32'd20, 32'd6, s, e, w, h, l, x);
    n_cmp++; if (s !== 33 || l !== 32'd3 || h !== 32'd2) begin n_err++; $display("FAIL b2b_second got s%0d lo %h hi %h exp 33/3/2", s, l, h); end
    do_div(8'h1B, 32'hFFFF_FFFF, 32'h0001_0000, s, e, w, h, l, x);
    n_cmp++; if (s !== 33 || w !== 1'b1 || l !== 32'h0000_FFFF || h !== 32'h0000_FFFF) begin n_err++; $display("FAIL b2b_third got s%0d w%0b lo %h hi %h exp 33/1/ffff/ffff", s, w, l, h); end
    @(posedge clk); #1;
    drive(3'b000, 8'h00, 32'd0, 32'd0);
  endtask

  initial begin
    test_reset;
    test_logic;
    test_arith;
    test_shift;
    test_divu;
    test_div_signed;
    test_flush;
    test_reset_mid_busy;
    test_back_to_back;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
